rd_stream_adapter: RTL and testbench



---
 rtl/rd_stream_adapter_pkg.sv | 18 +
 rtl/rd_stream_adapter_if.sv | 29 ++
 rtl/rd_stream_adapter_obuf.sv | 62 ++++++
 rtl/rd_stream_adapter.sv | 69 ++++++
 tb/tb_rd_stream_adapter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rd_stream_adapter_pkg.sv
// Shared defaults and sizing helpers for the read-side stream adapter.
package rd_stream_adapter_pkg;

  localparam int unsigned DATASIZE_DEF   = 8;
  localparam int unsigned ADDRSIZE_DEF   = 4;
  localparam int unsigned OBUF_DEPTH_DEF = 2;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width for a circular buffer of 'depth' entries (never below one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rd_stream_adapter_if.sv
// FIFO read port plus valid/ready stream bundle; master is the adapter's view.
interface rd_stream_adapter_if
  import rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATASIZE   = DATASIZE_DEF,
  parameter int unsigned OBUF_DEPTH = OBUF_DEPTH_DEF
);

  localparam int unsigned CNTW = cnt_width(OBUF_DEPTH);

  logic                rempty;
  logic                rq;
  logic [DATASIZE-1:0] rdata;
  logic [DATASIZE-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic [CNTW-1:0]     obuf_cnt;

  modport master (
    input  rempty, rdata, m_ready,
    output rq, m_data, m_valid, obuf_cnt
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rq, m_data, m_valid, obuf_cnt
  );

endinterface

// File: rtl/rd_stream_adapter_obuf.sv
// Register-based circular output buffer with write/read pointers and an occupancy count.
module rd_stream_adapter_obuf
  import rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATASIZE   = DATASIZE_DEF,
  parameter int unsigned OBUF_DEPTH = OBUF_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATASIZE-1:0]              wr_data,
  input  logic                             rd_en,
  output logic [DATASIZE-1:0]              rd_data,
  output logic [cnt_width(OBUF_DEPTH)-1:0] occ
);

  localparam int unsigned CNTW = cnt_width(OBUF_DEPTH);
  localparam int unsigned PTRW = ptr_width(OBUF_DEPTH);

  logic [DATASIZE-1:0] mem [OBUF_DEPTH];
  logic [PTRW-1:0]     wr_ptr;
  logic [PTRW-1:0]     rd_ptr;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(OBUF_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Storage carries no reset; contents are only observed while occ != 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      occ <= occ + CNTW'(wr_en) - CNTW'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];

  a_occ_bound : assert property (@(posedge clk) disable iff (rst)
    occ <= CNTW'(OBUF_DEPTH));

  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    rd_en |-> (occ != '0));

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    (wr_en && !rd_en) |-> (occ < CNTW'(OBUF_DEPTH)));

endmodule

// File: rtl/rd_stream_adapter.sv
// Read-domain FIFO consumer: credit-based read requests, one-cycle memory latency
// absorbed by a small output buffer, presented as a valid/ready stream.
module rd_stream_adapter
  import rd_stream_adapter_pkg::*;
#(
  parameter int unsigned DATASIZE   = DATASIZE_DEF,
  parameter int unsigned OBUF_DEPTH = OBUF_DEPTH_DEF
) (
  input  logic                 rclk,
  input  logic                 rrst,
  rd_stream_adapter_if.master  bus
);

  localparam int unsigned CNTW = cnt_width(OBUF_DEPTH);
  localparam int unsigned PW   = CNTW + 1;

  logic                inflight;
  logic                acc;
  logic                pop;
  logic                credit_ok;
  logic                rq_int;
  logic                valid_int;
  logic [CNTW-1:0]     occ;
  logic [PW-1:0]       pending;
  logic [DATASIZE-1:0] head_data;

  assign valid_int = (occ != '0);
  assign pop       = valid_int & bus.m_ready;

  // Slots committed after this cycle's pop; m_ready -> rq is combinational on purpose.
  assign pending   = PW'(occ) + PW'(inflight) - PW'(pop);
  assign credit_ok = (pending < PW'(OBUF_DEPTH));
  assign rq_int    = ~rrst & ~bus.rempty & credit_ok;
  assign acc       = rq_int & ~bus.rempty;

  // The accepted read returns data on the following cycle.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= acc;
    end
  end

  rd_stream_adapter_obuf #(
    .DATASIZE   (DATASIZE),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk     (rclk),
    .rst     (rrst),
    .wr_en   (inflight),
    .wr_data (bus.rdata),
    .rd_en   (pop),
    .rd_data (head_data),
    .occ     (occ)
  );

  assign bus.rq       = rq_int;
  assign bus.m_valid  = valid_int;
  assign bus.m_data   = head_data;
  assign bus.obuf_cnt = occ + CNTW'(inflight);

  a_stall_stable : assert property (@(posedge rclk) disable iff (rrst)
    (valid_int && !bus.m_ready) |=> (valid_int && $stable(head_data)));

  a_credit_bound : assert property (@(posedge rclk) disable iff (rrst)
    (PW'(occ) + PW'(inflight)) <= PW'(OBUF_DEPTH));

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Scoreboard bench for rd_stream_adapter with a behavioural FIFO read port.
module tb_rd_stream_adapter;
  import rd_stream_adapter_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned D    = 2;

  logic rclk = 1'b0;
  logic rrst = 1'b1;

  rd_stream_adapter_if #(.DATASIZE(DW), .OBUF_DEPTH(D)) bus ();

  rd_stream_adapter #(.DATASIZE(DW), .OBUF_DEPTH(D)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_rq  = 0;
  int n_del = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO read side: registered empty, data one cycle after an accepted read.
  always @(posedge rclk) begin
    logic [DW-1:0] w;
    if (!rrst && bus.rq && !bus.rempty) begin
      w = fifo_q.pop_front();
      bus.rdata <= w;
      n_acc++;
    end
    bus.rempty <= (fifo_q.size() == 0);
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge rclk) begin
    logic [DW-1:0] e;
    #2;
    if (rrst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.rq) n_rq++;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(bus.m_valid), 32'd1);
        chk("stall_data_held", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        n_del++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", 32'(bus.m_data), 32'(e));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc;
    int base_rq;
    int base_del;
    bit reached;
    logic [DW-1:0] seq;

    bus.m_ready = 1'b1;
    rrst = 1'b1;

    // Reset with data available: nothing requested, nothing presented.
    repeat (2) @(negedge rclk);
    for (int i = 1; i <= 16; i++) push(DW'(i));
    repeat (2) @(negedge rclk);
    #1;
    chk("rst_rq", 32'(bus.rq), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_obuf_cnt", 32'(bus.obuf_cnt), 32'd0);

    // Streaming at full rate; m_valid two cycles after the first request.
    @(negedge rclk);
    rrst = 1'b0;
    #1;
    chk("release_rq", 32'(bus.rq), 32'd1);
    chk("release_m_valid", 32'(bus.m_valid), 32'd0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge rclk);
      #1;
      chk($sformatf("stream_valid_c%0d", c), 32'(bus.m_valid),
          ((c >= 2) && (c <= 17)) ? 32'd1 : 32'd0);
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: two reads fill the buffer, head word held.
    @(negedge rclk);
    bus.m_ready = 1'b0;
    base_acc = n_acc;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    repeat (8) @(negedge rclk);
    #1;
    chk("bp_accepts", 32'(n_acc - base_acc), 32'd2);
    chk("bp_rq", 32'(bus.rq), 32'd0);
    chk("bp_obuf_cnt", 32'(bus.obuf_cnt), 32'd2);
    chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_m_data", 32'(bus.m_data), 32'h01);
    @(negedge rclk);
    bus.m_ready = 1'b1;
    repeat (12) @(negedge rclk);
    #1;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_total_accepts", 32'(n_acc - base_acc), 32'd5);
    chk("bp_idle_valid", 32'(bus.m_valid), 32'd0);
    chk("bp_idle_cnt", 32'(bus.obuf_cnt), 32'd0);

    // Single word then empty: one request pulse.
    base_acc = n_acc;
    base_rq  = n_rq;
    push(8'hA5);
    repeat (6) @(negedge rclk);
    #1;
    chk("empty_accepts", 32'(n_acc - base_acc), 32'd1);
    chk("empty_rq_pulses", 32'(n_rq - base_rq), 32'd1);
    chk("empty_m_valid", 32'(bus.m_valid), 32'd0);
    chk("empty_drained", 32'(exp_q.size()), 32'd0);

    // Random ready and random FIFO fill.
    seq = 8'h40;
    for (int i = 0; i < 400; i++) begin
      @(negedge rclk);
      bus.m_ready = 1'($urandom_range(1, 0));
      if ($urandom_range(2, 0) == 0) begin
        push(seq);
        seq = seq + 8'd1;
      end
      #1;
      chk("rand_cnt_bound", 32'(bus.obuf_cnt <= 2'(D)), 32'd1);
    end
    @(negedge rclk);
    bus.m_ready = 1'b1;
    repeat (20) @(negedge rclk);
    #1;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset while the buffer holds credit for two words.
    @(negedge rclk);
    bus.m_ready = 1'b0;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge rclk);
      #1;
      if (bus.obuf_cnt == 2'd2) reached = 1'b1;
    end
    chk("mid_rst_fill_reached", 32'(reached), 32'd1);
    rrst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_rst_obuf_cnt", 32'(bus.obuf_cnt), 32'd0);
    chk("mid_rst_rq", 32'(bus.rq), 32'd0);
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    bus.m_ready = 1'b1;
    base_del = n_del;
    push(8'h77);
    push(8'h78);
    repeat (8) @(negedge rclk);
    #1;
    chk("post_rst_delivered", 32'(n_del - base_del), 32'd2);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
